draw_control: RTL and testbench

Front-end controller for the random-draw unit. It turns the raw Key_0 push-button into the draw index Z and the hold flag t that the number-selection stage consumes. Each debounced press freezes the displayed number for a fixed hold window, then advances Z. After MAX_DRAWS presses the block stops advancing and reports completion.

---
 rtl/draw_pkg.sv | 22 ++
 rtl/draw_control_if.sv | 15 +
 rtl/key_debounce.sv | 59 +++++
 rtl/draw_control.sv | 91 +++++++++
 tb/tb_draw_control.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/draw_pkg.sv
// Shared types and default constants for the random-draw front end.
// Defaults assume a 50 MHz system clock.
package draw_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    DONE
  } state_t;

  localparam int CLK_HZ            = 50_000_000;
  localparam int DB_DEFAULT        = CLK_HZ / 50;  // 20 ms
  localparam int HOLD_DEFAULT      = CLK_HZ * 4;   // 4 s
  localparam int MAX_DRAWS_DEFAULT = 4;
  localparam int Z_W               = 4;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/draw_control_if.sv
// Key input and draw outputs exchanged between the draw controller and the
// number-selection stage.
interface draw_control_if;
  import draw_pkg::*;

  logic           key_n;
  logic [Z_W-1:0] Z;
  logic           t;
  logic           done;
  logic           press;

  modport master (output key_n, input Z, t, done, press);
  modport slave  (input key_n, output Z, t, done, press);

endinterface

// File: rtl/key_debounce.sv
// Two-flop synchroniser, level debouncer and falling-edge pulse for one
// active-low push-button. Reusable for any of the board keys.
module key_debounce
  import draw_pkg::*;
#(
  parameter int DB_CYCLES = DB_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic level,
  output logic fall_pulse
);

  localparam int              DB_W    = cnt_width(DB_CYCLES);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

  logic            r_sync1;
  logic            r_sync2;
  logic            r_level;
  logic            r_fall;
  logic [DB_W-1:0] r_cnt;

  // Both stages reset to the released level so reset never looks like a press.
  // NOTE: non-blocking assignments make every register update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= key_n;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_level <= 1'b1;
      r_cnt   <= '0;
      r_fall  <= 1'b0;
    end else begin
      r_fall <= 1'b0;
      if (r_sync2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == DB_LAST) begin
        // Level accepted; the pulse lines up with the cycle the level reads low.
        r_level <= r_sync2;
        r_cnt   <= '0;
        r_fall  <= ~r_sync2;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign level      = r_level;
  assign fall_pulse = r_fall;

endmodule

// File: rtl/draw_control.sv
// Draw controller: each debounced Key_0 press freezes the display for a hold
// window, then advances the draw index Z until MAX_DRAWS draws are complete.
module draw_control
  import draw_pkg::*;
#(
  parameter int DB_CYCLES   = DB_DEFAULT,
  parameter int HOLD_CYCLES = HOLD_DEFAULT,
  parameter int MAX_DRAWS   = MAX_DRAWS_DEFAULT
) (
  input  logic           clk,
  input  logic           rst,
  draw_control_if.slave  bus
);

  localparam int                HOLD_W    = cnt_width(HOLD_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [Z_W-1:0]    Z_MAX     = Z_W'(MAX_DRAWS);

  logic              w_level;
  logic              w_press;
  logic              w_accept;

  state_t            r_state;
  logic [HOLD_W-1:0] r_hold_cnt;
  logic [Z_W-1:0]    r_z;
  logic              r_t;
  logic              r_done;

  key_debounce #(
    .DB_CYCLES (DB_CYCLES)
  ) u_key0 (
    .clk        (clk),
    .rst        (rst),
    .key_n      (bus.key_n),
    .level      (w_level),
    .fall_pulse (w_press)
  );

  assign w_accept = w_press & ~w_level;

  // Presses arriving outside IDLE fall through untouched: nothing is queued.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_hold_cnt <= '0;
      r_z        <= '0;
      r_t        <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_t <= 1'b0;
          if (w_accept) begin
            r_state    <= HOLD;
            r_t        <= 1'b1;
            r_hold_cnt <= '0;
          end
        end
        HOLD: begin
          if (r_hold_cnt == HOLD_LAST) begin
            r_t        <= 1'b0;
            r_hold_cnt <= '0;
            r_z        <= r_z + 1'b1;
            if (r_z + 1'b1 == Z_MAX) begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= IDLE;
            end
          end else begin
            r_hold_cnt <= r_hold_cnt + 1'b1;
          end
        end
        DONE: begin
          r_t    <= 1'b0;
          r_done <= 1'b1;
        end
        default: begin
          r_state <= IDLE;
          r_t     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.Z     = r_z;
  assign bus.t     = r_t;
  assign bus.done  = r_done;
  assign bus.press = w_press;

endmodule

// File: tb/tb_draw_control.sv
// Directed and randomized checks of draw_control against a window-based
// reference model of debounce, hold window and draw counting.
module tb_draw_control;
  import draw_pkg::*;

  localparam int DB   = 4;
  localparam int HOLD = 10;
  localparam int MAXD = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  draw_control_if bus ();

  draw_control #(
    .DB_CYCLES   (DB),
    .HOLD_CYCLES (HOLD),
    .MAX_DRAWS   (MAXD)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: history of key samples, accepted level, hold time left.
  logic m_hist[$];
  logic m_level;
  logic m_press;
  int   m_hold_left;
  int   m_z;
  logic m_done;

  int press_cnt;
  int press_at;
  int t_cnt;
  int step_no;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_hist.delete();
    for (int i = 0; i < DB + 2; i++) m_hist.push_back(1'b1);
    m_level     = 1'b1;
    m_press     = 1'b0;
    m_hold_left = 0;
    m_z         = 0;
    m_done      = 1'b0;
  endtask

  // One clock edge. The FSM reacts to the press visible before the edge; the
  // level flips once the last DB synchronised samples all disagree with it.
  task automatic model_edge(input logic k);
    bit all_diff;
    if (!m_done) begin
      if (m_hold_left > 0) begin
        m_hold_left--;
        if (m_hold_left == 0) begin
          m_z++;
          if (m_z == MAXD) m_done = 1'b1;
        end
      end else if (m_press) begin
        m_hold_left = HOLD;
      end
    end
    m_hist.push_back(k);
    all_diff = 1'b1;
    for (int i = 0; i < DB; i++)
      if (m_hist[m_hist.size() - 3 - i] == m_level) all_diff = 1'b0;
    m_press = 1'b0;
    if (all_diff) begin
      m_level = ~m_level;
      m_press = (m_level == 1'b0);
    end
    if (m_hist.size() > 32) void'(m_hist.pop_front());
  endtask

  task automatic step(input logic k);
    bus.key_n = k;
    @(posedge clk);
    model_edge(k);
    @(negedge clk);
    step_no++;
    chk("press", 8'(bus.press), 8'(m_press));
    chk("t",     8'(bus.t),     8'(m_hold_left > 0));
    chk("Z",     8'(bus.Z),     8'(m_z));
    chk("done",  8'(bus.done),  8'(m_done));
    if (bus.press === 1'b1) begin
      press_cnt++;
      if (press_at < 0) press_at = step_no;
    end
    if (bus.t === 1'b1) t_cnt++;
  endtask

  task automatic steps(input logic k, input int n);
    for (int i = 0; i < n; i++) step(k);
  endtask

  // Called at a falling edge; reset rises between clock edges.
  task automatic do_reset();
    #2;
    rst = 1'b1;
    #1;
    chk("rst_t",     8'(bus.t),     8'd0);
    chk("rst_Z",     8'(bus.Z),     8'd0);
    chk("rst_done",  8'(bus.done),  8'd0);
    chk("rst_press", 8'(bus.press), 8'd0);
    bus.key_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    press_cnt = 0;
    press_at  = -1;
    t_cnt     = 0;
    step_no   = 0;
  endtask

  initial begin
    bus.key_n = 1'b1;
    model_reset();
    @(negedge clk);

    // 1: clean press, latency and hold window length
    do_reset();
    steps(1'b0, 20);
    chk("t1_press_cnt", 8'(press_cnt), 8'd1);
    chk("t1_press_at",  8'(press_at),  8'd6);
    chk("t1_t_len",     8'(t_cnt),     8'd10);
    chk("t1_z",         8'(bus.Z),     8'd1);
    steps(1'b1, 10);

    // 2: bouncing key accepted once after DB stable samples
    do_reset();
    step(1'b0); step(1'b0); step(1'b1);
    step(1'b0); step(1'b0); step(1'b0);
    steps(1'b0, 20);
    steps(1'b1, 10);
    chk("t2_press_cnt", 8'(press_cnt), 8'd1);
    chk("t2_press_at",  8'(press_at),  8'd9);
    chk("t2_t_len",     8'(t_cnt),     8'd10);
    chk("t2_z",         8'(bus.Z),     8'd1);

    // 3: second press lands inside the hold window and is ignored
    do_reset();
    steps(1'b0, 4);
    steps(1'b1, 4);
    steps(1'b0, 10);
    steps(1'b1, 12);
    chk("t3_press_cnt", 8'(press_cnt), 8'd2);
    chk("t3_t_len",     8'(t_cnt),     8'd10);
    chk("t3_z",         8'(bus.Z),     8'd1);

    // 4: four draws reach DONE; a fifth press changes nothing
    do_reset();
    for (int i = 0; i < MAXD; i++) begin
      steps(1'b0, 4);
      steps(1'b1, 16);
      chk("t4_z", 8'(bus.Z), 8'(i + 1));
    end
    chk("t4_done", 8'(bus.done), 8'd1);
    steps(1'b0, 4);
    steps(1'b1, 16);
    chk("t4_press5", 8'(press_cnt), 8'd5);
    chk("t4_z5",     8'(bus.Z),     8'd4);
    chk("t4_t5",     8'(bus.t),     8'd0);
    chk("t4_done5",  8'(bus.done),  8'd1);

    // 5: asynchronous reset at hold cycle 5, then a full window again
    do_reset();
    steps(1'b0, 4);
    steps(1'b1, 7);
    chk("t5_t_mid", 8'(t_cnt), 8'd5);
    do_reset();
    steps(1'b0, 4);
    steps(1'b1, 16);
    chk("t5_t_len", 8'(t_cnt), 8'd10);
    chk("t5_z",     8'(bus.Z), 8'd1);

    // 6: key held low for a long time gives a single draw
    do_reset();
    steps(1'b0, 100);
    chk("t6_press_cnt", 8'(press_cnt), 8'd1);
    chk("t6_t_len",     8'(t_cnt),     8'd10);
    chk("t6_z",         8'(bus.Z),     8'd1);
    steps(1'b1, 10);

    // Random key activity: short bounces mixed with long presses and releases
    for (int r = 0; r < 6; r++) begin
      int   n;
      int   d;
      logic lv;
      do_reset();
      n = 0;
      while (n < 400) begin
        lv = 1'($urandom_range(0, 1));
        d  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(10, 30))
                                         : int'($urandom_range(1, 6));
        steps(lv, d);
        n += d;
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
